// File: rtl/dot_matrix_pkg.sv
// Shared constants for the 8x8 dot matrix driver: glyph font and codes.
// Optional blink support in the top is enabled with DOT_BLINK_EN.
package dot_matrix_pkg;

    localparam int ROWS = 8;
    localparam logic [4:0] BLANK_CODE = 5'b10000;

    // FONT[digit][row], bit7 = leftmost column, row 0 = top.
    localparam logic [7:0] FONT [16][8] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00},
        '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00},
        '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00},
        '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00},
        '{8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00},
        '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00},
        '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h60, 8'h00}
    };

    function automatic logic [7:0] row_sel(
        input logic [2:0] idx,
        input logic       active_low
    );
        logic [7:0] oh;
        oh = 8'h01 << idx;
        return active_low ? ~oh : oh;
    endfunction

endpackage

// File: rtl/dot_matrix_driver_font_rom.sv
// Combinational glyph row lookup into the shared FONT table.
import dot_matrix_pkg::*;

module dot_font_rom (
    input  logic [3:0] digit,
    input  logic [2:0] row,
    output logic [7:0] col
);

    assign col = FONT[digit][row];

endmodule

// File: rtl/dot_matrix_driver.sv
// Row-scanning 8x8 LED hex-glyph driver, one row per TICK_DIV clocks.
// Define DOT_BLINK_EN to add the blink input and 64-frame blink counter.
import dot_matrix_pkg::*;

module dot_matrix_driver #(
    parameter int TICK_DIV       = 50000,
    parameter int ROW_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] code_in,
    output logic [7:0] dot_row,
    output logic [7:0] dot_col,
    output logic       frame_start
`ifdef DOT_BLINK_EN
    ,
    input  logic       blink
`endif
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic       LOW  = (ROW_ACTIVE_LOW != 0);
    localparam logic [7:0] DESEL = LOW ? 8'hFF : 8'h00;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_row_idx;
    logic [4:0]    r_disp_code;
    logic [7:0]    r_dot_row;
    logic [7:0]    r_dot_col;
    logic          r_frame_start;

    logic          w_tick;
    logic          w_frame_edge;
    logic [2:0]    w_row_next;
    logic [4:0]    w_code_use;
    logic [7:0]    w_glyph_col;
    logic [7:0]    w_col_next;

`ifdef DOT_BLINK_EN
    logic [5:0]    r_frame_cnt;
    logic [5:0]    w_cnt_next;
`endif

    dot_font_rom u_font (
        .digit (w_code_use[3:0]),
        .row   (w_row_next),
        .col   (w_glyph_col)
    );

    // The frame edge uses the freshly sampled code so row 0 of the new
    // frame already shows the new glyph.
    always_comb begin
        w_tick       = (r_presc == PW'(TICK_DIV - 1));
        w_row_next   = r_row_idx + 3'd1;
        w_frame_edge = w_tick && (r_row_idx == 3'd7);
        w_code_use   = w_frame_edge ? code_in : r_disp_code;
        w_col_next   = w_code_use[4] ? 8'h00 : w_glyph_col;
`ifdef DOT_BLINK_EN
        w_cnt_next   = w_frame_edge ? r_frame_cnt + 6'd1 : r_frame_cnt;
        if (blink && w_cnt_next[5])
            w_col_next = 8'h00;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc       <= '0;
            r_row_idx     <= 3'd0;
            r_disp_code   <= BLANK_CODE;
            r_dot_row     <= DESEL;
            r_dot_col     <= 8'h00;
            r_frame_start <= 1'b0;
        end else begin
            r_presc       <= w_tick ? '0 : r_presc + PW'(1);
            r_frame_start <= w_frame_edge;
            if (w_tick) begin
                r_row_idx <= w_row_next;
                r_dot_row <= row_sel(w_row_next, LOW);
                r_dot_col <= w_col_next;
            end
            if (w_frame_edge)
                r_disp_code <= code_in;
        end
    end

`ifdef DOT_BLINK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_frame_cnt <= 6'd0;
        else
            r_frame_cnt <= w_cnt_next;
    end
`endif

    assign dot_row     = r_dot_row;
    assign dot_col     = r_dot_col;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_dot_matrix_driver.sv
// Randomized bench for dot_matrix_driver against a time-based scan model.
import dot_matrix_pkg::*;

module tb_dot_matrix_driver;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] code_in = 5'h01;
    logic [7:0] dot_row;
    logic [7:0] dot_col;
    logic       frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    dot_matrix_driver #(
        .TICK_DIV       (TD),
        .ROW_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .code_in     (code_in),
        .dot_row     (dot_row),
        .dot_col     (dot_col),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference: count edges since reset release; every TD-th edge is a
    // row slot k, showing row k mod 8; code_in is taken when k mod 8 == 0.
    int         m_n;
    logic [7:0] m_row;
    logic [7:0] m_col;
    logic       m_fs;
    logic [4:0] m_code;

    function automatic logic [7:0] glyph(input logic [4:0] c, input int r);
        logic [3:0] d;
        d = c[3:0];
        return c[4] ? 8'h00 : FONT[d][r];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n    <= 0;
            m_row  <= 8'hFF;
            m_col  <= 8'h00;
            m_fs   <= 1'b0;
            m_code <= 5'h10;
        end else begin
            m_n  <= m_n + 1;
            m_fs <= 1'b0;
            if ((m_n + 1) % TD == 0) begin
                m_row <= ~(8'h01 << (((m_n + 1) / TD) % 8));
                if (((m_n + 1) / TD) % 8 == 0) begin
                    m_code <= code_in;
                    m_col  <= glyph(code_in, 0);
                    m_fs   <= 1'b1;
                end else begin
                    m_col <= glyph(m_code, ((m_n + 1) / TD) % 8);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("row", {24'h0, dot_row}, {24'h0, m_row});
            chk("col", {24'h0, dot_col}, {24'h0, m_col});
            chk("fs", {31'h0, frame_start}, {31'h0, m_fs});
            chk("onehot", {31'h0, $countones(~dot_row) <= 1}, 32'h1);
        end
    end

    logic [7:0] g1 [8] = '{8'h18, 8'h38, 8'h18, 8'h18,
                           8'h18, 8'h18, 8'h3C, 8'h00};
    int first_fs;
    bit found;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_row", {24'h0, dot_row}, 32'hFF);
        chk("rst_col", {24'h0, dot_col}, 32'h00);
        chk("rst_fs", {31'h0, frame_start}, 32'h0);
        rst_n = 1'b1;

        first_fs = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (frame_start && first_fs == 0) first_fs = i;
            if (i <= 3) chk("pre_tick", {24'h0, dot_row}, 32'hFF);
            if (i >= 32 && i < 64 && (i - 32) % 4 == 0)
                chk("g1", {24'h0, dot_col}, {24'h0, g1[(i - 32) / 4]});
            if (i >= 80 && i < 96 && (i - 64) % 4 == 0)
                chk("g1_hold", {24'h0, dot_col}, {24'h0, g1[(i - 64) / 4]});
            if (i == 76) code_in = 5'h00;
            if (i == 96) chk("g0_row0", {24'h0, dot_col}, 32'h3C);
        end
        chk("first_fs", first_fs, 32);

        code_in = 5'h10;
        repeat (64) @(negedge clk);

        code_in = 5'h01;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (dot_row == 8'hDF) found = 1;
        end
        chk("find_row5", {31'h0, found}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_row", {24'h0, dot_row}, 32'hFF);
        chk("async_col", {24'h0, dot_col}, 32'h00);
        chk("async_fs", {31'h0, frame_start}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        first_fs = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 4) chk("re_row1", {24'h0, dot_row}, 32'hFD);
            if (frame_start && first_fs == 0) first_fs = i;
        end
        chk("re_first_fs", first_fs, 32);

        for (int d = 0; d < 16; d++) begin
            code_in = 5'(d);
            repeat (32) @(negedge clk);
        end

        for (int i = 0; i < 60; i++) begin
            code_in = 5'($urandom_range(0, 31));
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_matrix_driver.md
Name: dot_matrix_driver

Overview:
- Row-scanning driver for the 8x8 LED dot matrix on the lab board.
- Consumes the 5-bit key code produced by the keypad scanner: 0x0-0xF = hex digit, bit4 set = no key.
- Renders the matching hex glyph by time-multiplexing one row at a time.
- Output side of the keypad front end: the scanner drives keypadRow and reads columns; this block drives dot_row/dot_col.

Parameters:
- TICK_DIV, 50000, clk cycles per row slot (50 MHz -> 1 kHz row rate, 125 Hz frame rate); legal range >= 2.
- ROW_ACTIVE_LOW, 1, 1 = selected row driven 0 and others 1; 0 = inverted polarity.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-low.
- code_in  in  5  key code; bit4=1 means blank, else [3:0] selects glyph 0-F.
- dot_row  out  8  one-hot row select, polarity per ROW_ACTIVE_LOW.
- dot_col  out  8  column pixel data for the selected row; 1 = LED on; bit7 = leftmost.
- frame_start  out  1  one-cycle pulse when row 0 becomes active.

Behaviour:
- Reset (async, reset=0):
  - prescaler=0, row_idx=0, disp_code=5'b10000.
  - dot_row = all rows deselected (8'hFF when ROW_ACTIVE_LOW=1).
  - dot_col=8'h00, frame_start=0.
- Prescaler: counts 0..TICK_DIV-1 and wraps; tick asserts for the single cycle where prescaler==TICK_DIV-1.
- On the tick clock edge:
  - row_idx <= row_idx+1, wrapping 7->0.
  - dot_row and dot_col are registered and update on the same edge to the new row, so there is no ghost cycle between row and column data.
- Frame latch:
  - code_in is sampled into disp_code only on the tick edge where row_idx goes 7->0, so a frame never tears.
  - Changes to code_in mid-frame are ignored until the next frame boundary.
  - frame_start=1 for exactly that one cycle.
- First frame after reset:
  - Outputs remain deselected/blank until the first tick.
  - The first tick selects row 1, not row 0, because row_idx increments from its reset value of 0.
  - The first code latch therefore happens 8 ticks after reset release; the display stays blank until then.
- Column data:
  - If disp_code[4]==1: dot_col=8'h00 (all codes 0x10-0x1F are blank).
  - Otherwise: dot_col = FONT[disp_code[3:0]][row_idx_next].
- Row data: row n selected means bit n of dot_row is active.
- Reset mid-frame: everything returns asynchronously to reset values; the scan restarts from the reset state.
- Unknown/X on code_in is not checked; it is only latched at the frame boundary.

Optional Feature:
- Macro DOT_BLINK_EN.
- Defined:
  - Adds input blink (1 bit) and a 6-bit frame counter, incremented on each frame_start.
  - While blink=1 and frame_cnt[5]=1, dot_col is forced to 8'h00; dot_row keeps scanning.
  - Blink period = 64 frames. The counter resets to 0 and free-runs.
- Undefined: no blink port, no counter; behaviour exactly as above.

Decomposition:
- Package dot_matrix_pkg:
  - FONT constant, 16 glyphs x 8 rows x 8 bits.
  - BLANK_CODE = 5'b10000.
  - ROWS = 8.
- Sub-module dot_font_rom: combinational glyph lookup (digit[3:0], row[2:0] -> col[7:0]) reading FONT.
- Required glyph '1': rows 0-7 = 18,38,18,18,18,18,3C,00 (hex).
- Required glyph '0': rows 0-7 = 3C,66,6E,76,66,66,3C,00 (hex).

Test Plan (TICK_DIV=4, ROW_ACTIVE_LOW=1):
- Reset, hold code_in=5'h01, release reset:
  - dot_row=FF and dot_col=00 until the first tick (4 clks).
  - The display stays blank until the first frame latch; frame_start pulses 32 clks after release.
  - After that latch, row0 shows dot_row=FE, dot_col=18.
  - Rows 1-7 show cols 38,18,18,18,18,3C,00 at 4-clk spacing.
- code_in=5'h10 latched -> dot_col=00 for all 8 rows; dot_row still walks FE,FD,FB,...,7F.
- code_in changes 5'h01 -> 5'h00 while row 3 is active:
  - Rows 4-7 still show glyph '1'.
  - Next frame row0 col=3C.
  - frame_start=1 for exactly one clk at the switch.
- Assert reset while row 5 is active -> outputs go to FF/00 asynchronously, before the next clk edge; after release the scan restarts from the reset state (first tick selects row 1, first latch 8 ticks later).
- Sweep code_in 0x0-0xF, one per frame -> each row's dot_col equals FONT entry; no cycle has two rows active or a row change without a column change on the same edge.
- (DOT_BLINK_EN) blink=1, code_in=5'h01:
  - Frames 0-31 show the glyph.
  - Frames 32-63 show dot_col=00 with rows still scanning.
  - Frame 64 shows the glyph again.
